// File: rtl/ascon_perm_sched_if.sv
// Bundle between the permutation scheduler, its two requesters (init and
// finalization) and the shared single-round Ascon core. The slave modport is
// the scheduler's view; the master modport is the surrounding logic's view.
interface ascon_perm_sched_if;
  logic         init_req_i;
  logic [319:0] init_state_i;
  logic         fin_req_i;
  logic [319:0] fin_state_i;
  logic         init_done_o;
  logic         fin_done_o;
  logic [319:0] result_o;
  logic         busy_o;
  logic [319:0] rnd_state_o;
  logic [7:0]   rnd_const_o;
  logic [319:0] rnd_state_i;

  modport slave (
    input  init_req_i, init_state_i, fin_req_i, fin_state_i, rnd_state_i,
    output init_done_o, fin_done_o, result_o, busy_o, rnd_state_o, rnd_const_o
  );

  modport master (
    output init_req_i, init_state_i, fin_req_i, fin_state_i, rnd_state_i,
    input  init_done_o, fin_done_o, result_o, busy_o, rnd_state_o, rnd_const_o
  );
endinterface

// File: rtl/ascon_perm_sched.sv
// Ascon permutation scheduler: round-robin arbiter between the init and
// finalization requesters in front of one shared single-round core. The
// granted 320-bit state is iterated NROUNDS times, then a one-cycle done
// pulse goes back to the granted requester.
// Optional build macro ASCON_PERM_ABORT_EN: when defined, dropping the
// granted request during RUN abandons the permutation without a done pulse.
module ascon_perm_sched #(
  parameter int NROUNDS = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  ascon_perm_sched_if.slave bus
);

`ifdef ASCON_PERM_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  // Constant index of the first round (p12 starts at 0, p6 at 6).
  localparam logic [3:0] K_START = 4'(12 - NROUNDS);
  localparam logic [3:0] R_LAST  = 4'(NROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e         fsm_q;
  logic [319:0] state_q;
  logic [3:0]   round_q;
  logic         gnt_fin_q;
  logic         last_fin_q;
  logic         init_done_q;
  logic         fin_done_q;
  logic         busy_q;

  logic         any_req_d;
  logic         pick_fin_d;
  logic         abort_d;
  logic [3:0]   k_d;
  logic [7:0]   const_d;

  // Arbitration decision, abort detection and round-constant generation.
  always_comb begin
    any_req_d  = bus.init_req_i | bus.fin_req_i;
    // Finalization wins when alone, or on a tie when init was served last.
    pick_fin_d = bus.fin_req_i & (~bus.init_req_i | ~last_fin_q);
    abort_d    = ABORT_EN & ~(gnt_fin_q ? bus.fin_req_i : bus.init_req_i);
    k_d        = K_START + round_q;
    const_d    = (fsm_q == RUN) ? {4'hF - k_d, k_d} : 8'h00;
  end

  // Scheduler FSM with its state register, round counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_q     <= '0;
      gnt_fin_q   <= 1'b0;
      last_fin_q  <= 1'b1;
      init_done_q <= 1'b0;
      fin_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (any_req_d) begin
            fsm_q      <= RUN;
            state_q    <= pick_fin_d ? bus.fin_state_i : bus.init_state_i;
            round_q    <= '0;
            gnt_fin_q  <= pick_fin_d;
            last_fin_q <= pick_fin_d;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (abort_d) begin
            // Abandoned run: state register keeps its value, no done pulse.
            fsm_q   <= IDLE;
            round_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= bus.rnd_state_i;
            round_q <= round_q + 4'd1;
            if (round_q == R_LAST) begin
              fsm_q       <= DONE;
              init_done_q <= ~gnt_fin_q;
              fin_done_q  <= gnt_fin_q;
            end
          end
        end
        DONE: begin
          fsm_q       <= IDLE;
          round_q     <= '0;
          init_done_q <= 1'b0;
          fin_done_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.init_done_o = init_done_q;
  assign bus.fin_done_o  = fin_done_q;
  assign bus.busy_o      = busy_q;
  assign bus.result_o    = state_q;
  assign bus.rnd_state_o = state_q;
  assign bus.rnd_const_o = const_d;

endmodule

// File: tb/tb_ascon_perm_sched.sv
// Testbench for ascon_perm_sched: a p12 and a p6 instance, each with a toy
// round core that XORs the round constant into the low byte of the state.
module tb_ascon_perm_sched;

  logic clk;
  logic rst_n;

  logic         init_req [2];
  logic         fin_req  [2];
  logic [319:0] init_st  [2];
  logic [319:0] fin_st   [2];

  logic         o_idone [2];
  logic         o_fdone [2];
  logic         o_busy  [2];
  logic [7:0]   o_const [2];
  logic [319:0] o_res   [2];
  logic [319:0] o_rst   [2];

  int checks = 0;
  int errors = 0;

  ascon_perm_sched_if if12 ();
  ascon_perm_sched_if if6 ();

  ascon_perm_sched #(.NROUNDS(12)) u12 (.clk(clk), .rst_n(rst_n), .bus(if12));
  ascon_perm_sched #(.NROUNDS(6))  u6  (.clk(clk), .rst_n(rst_n), .bus(if6));

  assign if12.init_req_i   = init_req[0];
  assign if12.fin_req_i    = fin_req[0];
  assign if12.init_state_i = init_st[0];
  assign if12.fin_state_i  = fin_st[0];
  assign if12.rnd_state_i  = if12.rnd_state_o ^ {312'b0, if12.rnd_const_o};
  assign if6.init_req_i    = init_req[1];
  assign if6.fin_req_i     = fin_req[1];
  assign if6.init_state_i  = init_st[1];
  assign if6.fin_state_i   = fin_st[1];
  assign if6.rnd_state_i   = if6.rnd_state_o ^ {312'b0, if6.rnd_const_o};

  assign o_idone[0] = if12.init_done_o;
  assign o_fdone[0] = if12.fin_done_o;
  assign o_busy[0]  = if12.busy_o;
  assign o_const[0] = if12.rnd_const_o;
  assign o_res[0]   = if12.result_o;
  assign o_rst[0]   = if12.rnd_state_o;
  assign o_idone[1] = if6.init_done_o;
  assign o_fdone[1] = if6.fin_done_o;
  assign o_busy[1]  = if6.busy_o;
  assign o_const[1] = if6.rnd_const_o;
  assign o_res[1]   = if6.result_o;
  assign o_rst[1]   = if6.rnd_state_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           d;
    bit           fin;
    logic [319:0] st;
    logic [319:0] exp;
  } vec_t;

  vec_t       tbl [5];
  logic [7:0] pconst [12];
  bit         mdl_last [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: apply the n constants {15-k, k}, k = 12-n .. 11, to the low byte.
  function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
    logic [319:0] x;
    x = s;
    for (int k = 12 - n; k < 12; k++) x[7:0] = x[7:0] ^ {4'(15 - k), 4'(k)};
    return x;
  endfunction

  task automatic chk_zero(input int d, input string nm);
    chk({nm, "_busy"},  320'(o_busy[d]),  '0);
    chk({nm, "_idone"}, 320'(o_idone[d]), '0);
    chk({nm, "_fdone"}, 320'(o_fdone[d]), '0);
    chk({nm, "_const"}, 320'(o_const[d]), '0);
    chk({nm, "_res"},   o_res[d],         '0);
    chk({nm, "_rst"},   o_rst[d],         '0);
  endtask

  // which: 0 = no done within bound, 1 = init_done, 2 = fin_done.
  task automatic wait_done(input int d, input int bound, output int which, output int cyc);
    which = 0;
    cyc   = 0;
    while (which == 0 && cyc < bound) begin
      tick();
      cyc++;
      if (o_idone[d]) which = 1;
      else if (o_fdone[d]) which = 2;
    end
  endtask

  task automatic run_one(input int d, input bit fin, input logic [319:0] st,
                         input logic [319:0] exp, input string nm);
    int n;
    n = (d == 1) ? 6 : 12;
    if (fin) begin fin_st[d] = st; fin_req[d] = 1'b1; end
    else     begin init_st[d] = st; init_req[d] = 1'b1; end
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) chk({nm, "_busy"}, 320'(o_busy[d]), 320'(1));
      chk({nm, "_const"}, 320'(o_const[d]), 320'(pconst[12 - n + i]));
    end
    tick();
    chk({nm, "_done"},  320'(fin ? o_fdone[d] : o_idone[d]), 320'(1));
    chk({nm, "_other"}, 320'(fin ? o_idone[d] : o_fdone[d]), '0);
    chk({nm, "_res"},   o_res[d], exp);
    init_req[d] = 1'b0;
    fin_req[d]  = 1'b0;
    tick();
    chk({nm, "_pulse"}, 320'(o_idone[d] | o_fdone[d]), '0);
    chk({nm, "_idle"},  320'(o_busy[d]), '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin init_req[d] = 1'b0; fin_req[d] = 1'b0; end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Both done outputs of one instance must never be high together.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (o_idone[d] || o_fdone[d]) begin
          checks++;
          if (o_idone[d] && o_fdone[d]) begin
            errors++;
            $display("FAIL both_done inst %0d got 11 want one-hot", d);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int which;
    int cyc;
    int n;
    int first;
    int exp_who;
    logic [1:0]   mode;
    logic [319:0] s, sf, prev;

    pconst = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
               8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    tbl[0] = '{d: 0, fin: 1'b0, st: 320'h0,  exp: 320'h0};
    tbl[1] = '{d: 1, fin: 1'b1, st: 320'h1,  exp: 320'h10};
    tbl[2] = '{d: 0, fin: 1'b0, st: 320'hFF, exp: 320'hFF};
    tbl[3] = '{d: 1, fin: 1'b0, st: 320'h0,  exp: 320'h11};
    tbl[4] = '{d: 0, fin: 1'b1, st: '1,      exp: '1};

    for (int d = 0; d < 2; d++) begin
      init_req[d] = 1'b0; fin_req[d] = 1'b0; init_st[d] = '0; fin_st[d] = '0;
    end
    rst_n = 1'b0;
    tick();
    chk_zero(0, "reset12");
    chk_zero(1, "reset6");
    rst_n = 1'b1;
    tick();

    // Single-requester vectors on both instances.
    for (int i = 0; i < 5; i++) run_one(tbl[i].d, tbl[i].fin, tbl[i].st, tbl[i].exp, $sformatf("vec%0d", i));

    // Input state changed every cycle after the grant edge.
    s = rnd320();
    init_st[0] = s;
    init_req[0] = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin init_st[0] = rnd320(); tick(); end
    chk("scramble_done", 320'(o_idone[0]), 320'(1));
    chk("scramble_res", o_res[0], s);
    init_req[0] = 1'b0;
    tick();

    // Finalization request dropped at round 5.
    s = rnd320();
    fin_st[0] = s;
    fin_req[0] = 1'b1;
    tick();
    chk("drop_busy", 320'(o_busy[0]), 320'(1));
    repeat (5) tick();
    fin_req[0] = 1'b0;
`ifdef ASCON_PERM_ABORT_EN
    prev = o_res[0];
    tick();
    chk("abort_busy", 320'(o_busy[0]), '0);
    chk("abort_res", o_res[0], prev);
    wait_done(0, 20, which, cyc);
    chk_i("abort_nodone", which, 0);
`else
    prev = '0;
    wait_done(0, 20, which, cyc);
    chk_i("drop_who", which, 2);
    chk_i("drop_lat", cyc, 7);
    chk("drop_res", o_res[0], s | prev);
    tick();
`endif

    // Contention from reset: init, fin, then init again.
    rst_n = 1'b0;
    s = rnd320();
    sf = rnd320();
    init_st[0] = s;
    fin_st[0] = sf;
    init_req[0] = 1'b1;
    fin_req[0] = 1'b1;
    tick();
    rst_n = 1'b1;
    wait_done(0, 40, which, cyc);
    chk_i("rr1_who", which, 1);
    chk_i("rr1_lat", cyc, 13);
    chk("rr1_res", o_res[0], s);
    init_req[0] = 1'b0;
    wait_done(0, 40, which, cyc);
    chk_i("rr2_who", which, 2);
    chk_i("rr2_lat", cyc, 14);
    chk("rr2_res", o_res[0], sf);
    init_req[0] = 1'b1;
    wait_done(0, 40, which, cyc);
    chk_i("rr3_who", which, 1);
    chk_i("rr3_lat", cyc, 14);
    init_req[0] = 1'b0;
    wait_done(0, 40, which, cyc);
    chk_i("rr4_who", which, 2);
    fin_req[0] = 1'b0;
    tick();

    // Reset asserted at round 5, request held across it.
    s = rnd320();
    init_st[0] = s;
    init_req[0] = 1'b1;
    tick();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk_zero(0, "midrst");
    tick();
    chk("midrst_hold", 320'(o_busy[0]), '0);
    rst_n = 1'b1;
    run_one(0, 1'b0, s, s, "rerun");

    // Randomized traffic against the reference model.
    do_reset();
    mdl_last[0] = 1'b1;
    mdl_last[1] = 1'b1;
    for (int t = 0; t < 24; t++) begin
      int d;
      d = int'($urandom_range(0, 1));
      mode = 2'($urandom_range(1, 3));
      n = (d == 1) ? 6 : 12;
      s = rnd320();
      sf = rnd320();
      init_st[d] = s;
      fin_st[d] = sf;
      init_req[d] = mode[0];
      fin_req[d] = mode[1];
      first = (mode == 2'd3) ? (mdl_last[d] ? 1 : 2) : int'(mode);
      for (int j = 0; j < ((mode == 2'd3) ? 2 : 1); j++) begin
        exp_who = (j == 0) ? first : 3 - first;
        wait_done(d, 40, which, cyc);
        chk_i("rand_who", which, exp_who);
        chk_i("rand_lat", cyc, (j == 0) ? n + 1 : n + 2);
        chk("rand_res", o_res[d], model_perm((exp_who == 1) ? s : sf, n));
        if (exp_who == 1) init_req[d] = 1'b0;
        else fin_req[d] = 1'b0;
        mdl_last[d] = (exp_who == 2);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
